pid_controller: RTL and testbench

Fixed-point discrete PID controller on a single clock, for a closed-loop feedback path, for example an ADC-to-DAC loop.
- Each cycle it forms error = set_point - data_in.
- It outputs the saturated sum of a proportional term, an integrated term and a differential term.
- Coefficients are raw signed integers with no internal scaling; downstream logic selects the output bits it needs.

---
 rtl/pid_controller.sv | 111 +++++++++++
 tb/tb_pid_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pid_controller.sv
// Fixed-point discrete PID controller.
// Three-stage pipeline: error, gain products, saturating integrate/sum.
module pid_controller #(
   parameter int DATA_WIDTH = 14
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic signed [DATA_WIDTH-1:0]   data_in,
   input  logic signed [DATA_WIDTH-1:0]   set_point,
   input  logic signed [DATA_WIDTH-1:0]   p_coef,
   input  logic signed [DATA_WIDTH-1:0]   i_coef,
   input  logic signed [DATA_WIDTH-1:0]   d_coef,
   output logic signed [2*DATA_WIDTH:0]   data_out
);

   localparam int W  = DATA_WIDTH;
   localparam int EW = W + 1;
   localparam int FW = W + 2;
   localparam int OW = 2 * W + 1;
   localparam int DW = 2 * W + 2;
   localparam int SW = 2 * W + 3;

   localparam logic signed [SW-1:0] MAX_V = {{3{1'b0}}, {(2*W){1'b1}}};
   localparam logic signed [SW-1:0] MIN_V = {{3{1'b1}}, {(2*W){1'b0}}};

   function automatic logic signed [OW-1:0] sat(
      input logic signed [SW-1:0] x
   );
      if (x > MAX_V) begin
         sat = MAX_V[OW-1:0];
      end else if (x < MIN_V) begin
         sat = MIN_V[OW-1:0];
      end else begin
         sat = x[OW-1:0];
      end
   endfunction

   logic signed [EW-1:0] error_q = '0;
   logic signed [EW-1:0] prev_q = '0;
   logic signed [OW-1:0] p_prod_q = '0;
   logic signed [OW-1:0] i_prod_q = '0;
   logic signed [DW-1:0] d_prod_q = '0;
   logic signed [OW-1:0] integ_q = '0;
   logic signed [OW-1:0] data_out_q = '0;

   logic signed [EW-1:0] error_d;
   logic signed [EW-1:0] prev_d;
   logic signed [OW-1:0] p_prod_d;
   logic signed [OW-1:0] i_prod_d;
   logic signed [DW-1:0] d_prod_d;
   logic signed [OW-1:0] integ_d;
   logic signed [OW-1:0] data_out_d;

   logic signed [FW-1:0] diff;
   logic signed [OW-1:0] e_ext;
   logic signed [OW-1:0] pc_ext;
   logic signed [OW-1:0] ic_ext;
   logic signed [DW-1:0] dc_ext;
   logic signed [DW-1:0] diff_ext;
   logic signed [SW-1:0] int_sum;
   logic signed [SW-1:0] out_sum;

   always_comb begin
      error_d = {set_point[W-1], set_point} - {data_in[W-1], data_in};
      prev_d  = error_q;

      // operands widened first so every product is exact
      e_ext    = {{(OW-EW){error_q[EW-1]}}, error_q};
      pc_ext   = {{(OW-W){p_coef[W-1]}}, p_coef};
      ic_ext   = {{(OW-W){i_coef[W-1]}}, i_coef};
      diff     = {error_q[EW-1], error_q} - {prev_q[EW-1], prev_q};
      diff_ext = {{(DW-FW){diff[FW-1]}}, diff};
      dc_ext   = {{(DW-W){d_coef[W-1]}}, d_coef};

      p_prod_d = pc_ext * e_ext;
      i_prod_d = ic_ext * e_ext;
      d_prod_d = dc_ext * diff_ext;

      int_sum = {{2{integ_q[OW-1]}}, integ_q}
              + {{2{i_prod_q[OW-1]}}, i_prod_q};
      integ_d = sat(int_sum);

      out_sum = {{2{p_prod_q[OW-1]}}, p_prod_q}
              + {{2{integ_d[OW-1]}}, integ_d}
              + {d_prod_q[DW-1], d_prod_q};
      data_out_d = sat(out_sum);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         error_q    <= '0;
         prev_q     <= '0;
         p_prod_q   <= '0;
         i_prod_q   <= '0;
         d_prod_q   <= '0;
         integ_q    <= '0;
         data_out_q <= '0;
      end else begin
         error_q    <= error_d;
         prev_q     <= prev_d;
         p_prod_q   <= p_prod_d;
         i_prod_q   <= i_prod_d;
         d_prod_q   <= d_prod_d;
         integ_q    <= integ_d;
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_pid_controller.sv
// Bench for pid_controller: sample-level reference model feeding a
// scoreboard queue, checked by an independent monitor every cycle.
module tb_pid_controller;

   localparam int W  = 14;
   localparam int OW = 2 * W + 1;
   localparam longint MAXV = (64'sd1 <<< (2 * W)) - 1;
   localparam longint MINV = -(64'sd1 <<< (2 * W));

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic signed [W-1:0]  data_in = '0;
   logic signed [W-1:0]  set_point = '0;
   logic signed [W-1:0]  p_coef = '0;
   logic signed [W-1:0]  i_coef = '0;
   logic signed [W-1:0]  d_coef = '0;
   logic signed [OW-1:0] data_out;

   always #5 clk = ~clk;

   pid_controller #(.DATA_WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .data_in(data_in),
      .set_point(set_point),
      .p_coef(p_coef),
      .i_coef(i_coef),
      .d_coef(d_coef),
      .data_out(data_out)
   );

   int n_tests = 0;
   int n_fail = 0;

   longint exp_q[$];
   bit     r_h[$];
   longint e_h[$];
   longint p_h[$];
   longint i_h[$];
   longint d_h[$];
   longint m_integ = 0;

   function automatic longint sat(input longint x);
      if (x > MAXV) return MAXV;
      if (x < MINV) return MINV;
      return x;
   endfunction

   // error seen by the pipeline after edge k (reset or pre-start gives 0)
   function automatic longint err_at(input int k);
      if (k < 0) return 0;
      if (r_h[k]) return 0;
      return e_h[k];
   endfunction

   function automatic longint prv_at(input int k);
      if (k < 0) return 0;
      if (r_h[k]) return 0;
      return err_at(k - 1);
   endfunction

   task automatic check(input string name, input longint act,
                        input longint exp, input bit xs);
      n_tests++;
      if (xs || act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (x=%0b) expected %0d",
                  name, act, xs, exp);
      end
   endtask

   task automatic model_step();
      int n;
      longint pp, ip, dp, ev;
      r_h.push_back(rst);
      e_h.push_back(longint'(set_point) - longint'(data_in));
      p_h.push_back(longint'(p_coef));
      i_h.push_back(longint'(i_coef));
      d_h.push_back(longint'(d_coef));
      n = r_h.size() - 1;
      if (r_h[n]) begin
         m_integ = 0;
         ev = 0;
      end else begin
         if (n < 1 || r_h[n-1]) begin
            pp = 0;
            ip = 0;
            dp = 0;
         end else begin
            pp = p_h[n-1] * err_at(n - 2);
            ip = i_h[n-1] * err_at(n - 2);
            dp = d_h[n-1] * (err_at(n - 2) - prv_at(n - 2));
         end
         m_integ = sat(m_integ + ip);
         ev = sat(pp + m_integ + dp);
      end
      exp_q.push_back(ev);
   endtask

   task automatic monitor_step();
      longint ev;
      if (exp_q.size() > 0) begin
         ev = exp_q.pop_front();
         check("data_out", longint'(data_out), ev, $isunknown(data_out));
      end
   endtask

   always @(posedge clk) model_step();
   always @(negedge clk) monitor_step();

   task automatic set_in(input int din, input int sp, input int p,
                         input int i, input int d);
      data_in   = W'(din);
      set_point = W'(sp);
      p_coef    = W'(p);
      i_coef    = W'(i);
      d_coef    = W'(d);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_zero", longint'(data_out), 0, $isunknown(data_out));
      rst = 1'b0;
   endtask

   task automatic basic_seq(input string tag);
      cycles(3);
      check({tag, "_e3"}, longint'(data_out), 8392704, $isunknown(data_out));
      cycles(1);
      check({tag, "_e4"}, longint'(data_out), 8392704, $isunknown(data_out));
      cycles(1);
      check({tag, "_e5"}, longint'(data_out), 8394752, $isunknown(data_out));
   endtask

   initial begin
      set_in(2048, 4096, 4096, 1, 1);
      #1;
      check("powerup", longint'(data_out), 0, $isunknown(data_out));
      cycles(10);

      pulse_rst();
      basic_seq("basic");
      cycles(8);

      p_coef = W'(128);
      cycles(10);

      pulse_rst();
      set_in(-8192, 8191, 8191, 8191, 8191);
      cycles(40);
      check("pos_sat", longint'(data_out), MAXV, $isunknown(data_out));

      set_in(8191, -8192, 8191, 8191, 0);
      cycles(40);
      check("neg_sat", longint'(data_out), MINV, $isunknown(data_out));

      set_in(-8192, 8191, 0, 8191, 0);
      cycles(6);

      pulse_rst();
      set_in(2048, 4096, 4096, 1, 1);
      cycles(12);
      pulse_rst();
      basic_seq("midrst");
      cycles(4);

      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 39) == 0);
         if (k < 200) begin
            data_in   = W'(int'($urandom_range(0, 400)) - 200);
            set_point = W'(int'($urandom_range(0, 400)) - 200);
            if ($urandom_range(0, 7) == 0) begin
               p_coef = W'(int'($urandom_range(0, 200)) - 100);
               i_coef = W'(int'($urandom_range(0, 20)) - 10);
               d_coef = W'(int'($urandom_range(0, 200)) - 100);
            end
         end else begin
            data_in   = W'($urandom);
            set_point = W'($urandom);
            p_coef    = W'($urandom);
            i_coef    = W'($urandom);
            d_coef    = W'($urandom);
         end
      end
      rst = 1'b0;
      cycles(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
